ex_alu_stage: RTL and testbench

Execute-stage ALU for the pipelined CPU. It accepts a 4-bit ALU control code from the ALU control decoder, together with two 32-bit operands and a destination register index, through a valid/ready handshake. It computes the result and holds it in an output register that forms the EX/MEM boundary. A multi-cycle iterative multiply can optionally be compiled in; while it runs, the stage stalls the upstream pipeline.

---
 rtl/cpu_pkg.sv | 48 ++++
 rtl/ex_alu_stage_if.sv | 28 ++
 rtl/iter_mul.sv | 82 ++++++++
 rtl/ex_alu_stage.sv | 127 ++++++++++++
 tb/tb_ex_alu_stage.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU types: ALU control codes, execute-stage states, result payload and ALU helper.
package cpu_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned MUL_CYCLES = XLEN;
    localparam int unsigned REG_IDX_W  = 5;
    localparam int unsigned ALU_CTL_W  = 4;
    localparam int unsigned MUL_CNT_W  = 6;

    typedef enum logic [ALU_CTL_W-1:0] {
        ALU_ADD    = 4'b0000,
        ALU_SUB    = 4'b0001,
        ALU_AND    = 4'b0010,
        ALU_OR     = 4'b0011,
        ALU_SUB_BR = 4'b0110,
        ALU_SLT    = 4'b0111,
        ALU_MUL    = 4'b1000
    } alu_ctl_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } ex_state_t;

    typedef struct packed {
        logic [XLEN-1:0]      result;
        logic                 zero;
        logic [REG_IDX_W-1:0] rd;
    } ex_rsp_t;

    // Single-cycle ALU; multiply and unknown codes yield 0 here
    function automatic logic [XLEN-1:0] alu_eval(input logic [ALU_CTL_W-1:0] ctl,
                                                 input logic [XLEN-1:0]      a,
                                                 input logic [XLEN-1:0]      b);
        logic [XLEN-1:0] r;
        r = '0;
        case (ctl)
            ALU_ADD:            r = a + b;
            ALU_SUB, ALU_SUB_BR: r = a - b;
            ALU_AND:            r = a & b;
            ALU_OR:             r = a | b;
            ALU_SLT:            r = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            default:            r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ex_alu_stage_if.sv
// Issue and result channels of the execute-stage ALU (valid/ready on both sides).
interface ex_alu_stage_if;
    import cpu_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [ALU_CTL_W-1:0] alu_ctl;
    logic [XLEN-1:0]      op_a;
    logic [XLEN-1:0]      op_b;
    logic [REG_IDX_W-1:0] rd_in;

    logic                 out_valid;
    logic                 out_ready;
    logic [XLEN-1:0]      result;
    logic                 zero;
    logic [REG_IDX_W-1:0] rd_out;

    modport master (
        output in_valid, alu_ctl, op_a, op_b, rd_in, out_ready,
        input  in_ready, out_valid, result, zero, rd_out
    );

    modport slave (
        input  in_valid, alu_ctl, op_a, op_b, rd_in, out_ready,
        output in_ready, out_valid, result, zero, rd_out
    );

endinterface

// File: rtl/iter_mul.sv
// Shift-add iterative multiplier, one multiplier bit per cycle, LSB first.
// Present only when EX_ALU_MUL_EN is defined.
`ifdef EX_ALU_MUL_EN
module iter_mul
    import cpu_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic            abort_i,
    input  logic            ack_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            done_c,
    output logic [XLEN-1:0] product_c,
    output logic            busy
);

    logic [MUL_CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]      acc_q, acc_d;
    logic [XLEN-1:0]      mcand_q, mcand_d;
    logic [XLEN-1:0]      mplier_q, mplier_d;
    logic                 hold_q, hold_d;
    logic                 busy_q, busy_d;
    logic [XLEN-1:0]      addend_c;

    assign addend_c = mplier_q[0] ? mcand_q : '0;

    // Product is offered during the final iteration, then held until acknowledged
    assign done_c    = (cnt_q == MUL_CNT_W'(1)) || hold_q;
    assign product_c = hold_q ? acc_q : (acc_q + addend_c);
    assign busy      = busy_q;

    always_comb begin
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        hold_d   = hold_q;
        if (abort_i) begin
            cnt_d  = '0;
            hold_d = 1'b0;
        end else if (start_i) begin
            cnt_d    = MUL_CNT_W'(MUL_CYCLES);
            acc_d    = '0;
            mcand_d  = a_i;
            mplier_d = b_i;
            hold_d   = 1'b0;
        end else if (cnt_q != '0) begin
            acc_d    = acc_q + addend_c;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - MUL_CNT_W'(1);
            if (cnt_q == MUL_CNT_W'(1)) begin
                hold_d = !ack_i;
            end
        end else if (ack_i) begin
            hold_d = 1'b0;
        end
        busy_d = (cnt_d != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            hold_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            hold_q   <= hold_d;
            busy_q   <= busy_d;
        end
    end

endmodule
`endif

// File: rtl/ex_alu_stage.sv
// Execute-stage ALU with registered EX/MEM result; stalls upstream while multiplying.
// Optional iterative multiply (code 1000) compiled in with EX_ALU_MUL_EN.
module ex_alu_stage
    import cpu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    output logic                 busy,
    ex_alu_stage_if.slave        bus
);

    ex_rsp_t                rsp_q, rsp_d;
    logic                   out_valid_q, out_valid_d;
    logic                   out_free_c;
    logic                   accept_c;
    logic                   load_c;
    logic [XLEN-1:0]        load_result_c;
    logic [REG_IDX_W-1:0]   load_rd_c;

    assign out_free_c = !out_valid_q || bus.out_ready;
    assign accept_c   = bus.in_valid && bus.in_ready;

`ifdef EX_ALU_MUL_EN
    ex_state_t              state_q, state_d;
    logic [REG_IDX_W-1:0]   mul_rd_q, mul_rd_d;
    logic                   is_mul_c;
    logic                   mul_start_c;
    logic                   mul_ack_c;
    logic                   mul_done_c;
    logic [XLEN-1:0]        mul_product_c;

    assign is_mul_c     = (bus.alu_ctl == ALU_MUL);
    assign bus.in_ready = (state_q == ST_IDLE) && out_free_c && !flush;

    // Next state; a finished product waits in MUL until the output register frees
    always_comb begin
        state_d     = state_q;
        mul_rd_d    = mul_rd_q;
        mul_start_c = accept_c && is_mul_c;
        mul_ack_c   = (state_q == ST_MUL) && mul_done_c && out_free_c && !flush;
        if (flush) begin
            state_d = ST_IDLE;
        end else if (mul_start_c) begin
            state_d  = ST_MUL;
            mul_rd_d = bus.rd_in;
        end else if (mul_ack_c) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            mul_rd_q <= '0;
        end else begin
            state_q  <= state_d;
            mul_rd_q <= mul_rd_d;
        end
    end

    iter_mul u_iter_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (mul_start_c),
        .abort_i   (flush),
        .ack_i     (mul_ack_c),
        .a_i       (bus.op_a),
        .b_i       (bus.op_b),
        .done_c    (mul_done_c),
        .product_c (mul_product_c),
        .busy      (busy)
    );

    always_comb begin
        load_c        = accept_c && !is_mul_c;
        load_result_c = alu_eval(bus.alu_ctl, bus.op_a, bus.op_b);
        load_rd_c     = bus.rd_in;
        if (mul_ack_c) begin
            load_c        = 1'b1;
            load_result_c = mul_product_c;
            load_rd_c     = mul_rd_q;
        end
    end
`else
    assign bus.in_ready = out_free_c && !flush;
    assign busy         = 1'b0;

    always_comb begin
        load_c        = accept_c;
        load_result_c = alu_eval(bus.alu_ctl, bus.op_a, bus.op_b);
        load_rd_c     = bus.rd_in;
    end
`endif

    // EX/MEM output register: loads only when empty or being consumed
    always_comb begin
        rsp_d       = rsp_q;
        out_valid_d = out_valid_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (load_c) begin
            out_valid_d  = 1'b1;
            rsp_d.result = load_result_c;
            rsp_d.zero   = (load_result_c == '0);
            rsp_d.rd     = load_rd_c;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            rsp_q       <= '{result: '0, zero: 1'b1, rd: '0};
        end else begin
            out_valid_q <= out_valid_d;
            rsp_q       <= rsp_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.result    = rsp_q.result;
    assign bus.zero      = rsp_q.zero;
    assign bus.rd_out    = rsp_q.rd;

endmodule

// File: tb/tb_ex_alu_stage.sv
// Self-checking bench for ex_alu_stage: directed scenarios plus random traffic
// compared against a transaction-level reference model.
module tb_ex_alu_stage;
    import cpu_pkg::*;

    logic clk;
    logic rst_n;
    logic flush;
    logic busy;

    ex_alu_stage_if bus();

    ex_alu_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .busy  (busy),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model state
    bit          m_valid;
    logic [31:0] m_res;
    logic [4:0]  m_rd;
    bit          m_pend;
    int          m_left;
    logic [31:0] m_mul_res;
    logic [4:0]  m_mul_rd;

    logic [3:0] codes [7];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [3:0] ctl, input logic [31:0] a,
                                            input logic [31:0] b);
        int sa;
        int sb;
        sa = a;
        sb = b;
        case (ctl)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd6: return a - b;
            4'd7: return (sa < sb) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = 64'(a) * 64'(b);
        return p[31:0];
    endfunction

    function automatic bit exp_in_ready(input bit ordy, input bit fl);
        return !m_pend && (!m_valid || ordy) && !fl;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_res   = 32'd0;
        m_rd    = 5'd0;
        m_pend  = 1'b0;
        m_left  = 0;
    endtask

    task automatic model_step(input bit v, input logic [3:0] ctl, input logic [31:0] a,
                              input logic [31:0] b, input logic [4:0] rd,
                              input bit ordy, input bit fl);
        bit acc;
        bit free;
        free = !m_valid || ordy;
        acc  = v && exp_in_ready(ordy, fl);
        if (fl) begin
            m_valid = 1'b0;
            m_pend  = 1'b0;
            m_left  = 0;
            return;
        end
        if (m_valid && ordy) m_valid = 1'b0;
        if (m_pend) begin
            if (m_left <= 1 && free) begin
                m_valid = 1'b1;
                m_res   = m_mul_res;
                m_rd    = m_mul_rd;
                m_pend  = 1'b0;
            end
            if (m_left > 0) m_left--;
        end else if (acc) begin
`ifdef EX_ALU_MUL_EN
            if (ctl == 4'b1000) begin
                m_pend    = 1'b1;
                m_left    = 32;
                m_mul_res = ref_mul(a, b);
                m_mul_rd  = rd;
            end else begin
                m_valid = 1'b1;
                m_res   = ref_alu(ctl, a, b);
                m_rd    = rd;
            end
`else
            m_valid = 1'b1;
            m_res   = ref_alu(ctl, a, b);
            m_rd    = rd;
`endif
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_out_valid"}, 32'(bus.out_valid), 32'(m_valid));
        check({tag, "_busy"},      32'(busy),          32'(m_left > 0));
        check({tag, "_result"},    bus.result,         m_res);
        check({tag, "_zero"},      32'(bus.zero),      32'(m_res == 32'd0));
        check({tag, "_rd_out"},    32'(bus.rd_out),    32'(m_rd));
    endtask

    // One clock: drive at posedge+1, check in_ready, step model at edge, check at posedge+1
    task automatic cycle(input bit v, input logic [3:0] ctl, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd, input bit ordy,
                         input bit fl, input string tag);
        bus.in_valid  = v;
        bus.alu_ctl   = ctl;
        bus.op_a      = a;
        bus.op_b      = b;
        bus.rd_in     = rd;
        bus.out_ready = ordy;
        flush         = fl;
        #1;
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'(exp_in_ready(ordy, fl)));
        @(posedge clk);
        model_step(v, ctl, a, b, rd, ordy, fl);
        #1;
        check_outputs(tag);
    endtask

    task automatic do_reset(input string tag);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        flush         = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs(tag);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_outputs({tag, "_rel"});
    endtask

    initial begin
        codes = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd6, 4'd7, 4'd8};
        rst_n         = 1'b1;
        bus.alu_ctl   = 4'd0;
        bus.op_a      = 32'd0;
        bus.op_b      = 32'd0;
        bus.rd_in     = 5'd0;
        do_reset("reset");

        // Back-to-back single-cycle ops
        cycle(1'b1, 4'd0, 32'd5, 32'd7, 5'd1, 1'b1, 1'b0, "b2b_add");
        check("tp_add_res", bus.result, 32'd12);
        cycle(1'b1, 4'd1, 32'd3, 32'd5, 5'd2, 1'b1, 1'b0, "b2b_sub");
        check("tp_sub_res", bus.result, 32'hFFFF_FFFE);
        cycle(1'b1, 4'd7, 32'hFFFF_FFFF, 32'd1, 5'd3, 1'b1, 1'b0, "b2b_slt");
        check("tp_slt_res", bus.result, 32'd1);
        check("tp_slt_rd", 32'(bus.rd_out), 32'd3);
        cycle(1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b1, 1'b0, "drain");

        // Backpressure: held result, stalled input, accept on out_ready rise
        cycle(1'b1, 4'd1, 32'd9, 32'd9, 5'd4, 1'b0, 1'b0, "bp_sub");
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 4'd0, 32'd2, 32'd3, 5'd5, 1'b0, 1'b0, "bp_hold");
            check("tp_bp_zero", 32'(bus.zero), 32'd1);
            check("tp_bp_result", bus.result, 32'd0);
        end
        cycle(1'b1, 4'd0, 32'd2, 32'd3, 5'd5, 1'b1, 1'b0, "bp_release");
        check("tp_bp_next", bus.result, 32'd5);

        // Unknown code
        cycle(1'b1, 4'b0101, 32'h0000_FFFF, 32'd0, 5'd6, 1'b1, 1'b0, "unknown");
        check("tp_unk_valid", 32'(bus.out_valid), 32'd1);
        check("tp_unk_zero", 32'(bus.zero), 32'd1);
        check("tp_unk_res", bus.result, 32'd0);

        // Multiply 0x10001 * 0x10001
        cycle(1'b1, 4'd8, 32'h0001_0001, 32'h0001_0001, 5'd7, 1'b1, 1'b0, "mul_go");
`ifndef EX_ALU_MUL_EN
        check("tp_mul_off_res", bus.result, 32'd0);
        check("tp_mul_off_zero", 32'(bus.zero), 32'd1);
`endif
        for (int i = 1; i <= 32; i++) begin
            cycle(1'b1, 4'd0, 32'd1, 32'd2, 5'd8, 1'b1, 1'b0, "mul_run");
        end
`ifdef EX_ALU_MUL_EN
        check("tp_mul_res", bus.result, 32'h0002_0001);
`endif
        cycle(1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b1, 1'b0, "drain");

        // Flush at N+10 of a multiply with an add presented
        cycle(1'b1, 4'd8, 32'h1234_5678, 32'h9ABC_DEF0, 5'd9, 1'b1, 1'b0, "fl_mul");
        for (int i = 1; i <= 9; i++) begin
            cycle(1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b1, 1'b0, "fl_run");
        end
        cycle(1'b1, 4'd0, 32'd4, 32'd4, 5'd10, 1'b1, 1'b1, "fl_hit");
        check("tp_fl_busy", 32'(busy), 32'd0);
        check("tp_fl_valid", 32'(bus.out_valid), 32'd0);
        cycle(1'b1, 4'd0, 32'd1, 32'd1, 5'd11, 1'b1, 1'b0, "fl_after");
        check("tp_fl_add", bus.result, 32'd2);

        // Reset in the middle of a multiply
        cycle(1'b1, 4'd8, 32'd3, 32'd5, 5'd12, 1'b1, 1'b0, "rst_mul");
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b1, 1'b0, "rst_run");
        end
        do_reset("mid_rst");

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            bit          v;
            bit          ordy;
            bit          fl;
            logic [3:0]  ctl;
            logic [31:0] a;
            logic [31:0] b;
            v    = ($urandom_range(0, 9) < 7);
            ctl  = ($urandom_range(0, 9) < 8) ? codes[$urandom_range(0, 6)] : 4'($urandom);
            a    = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            b    = ($urandom_range(0, 3) == 0) ? a : $urandom;
            ordy = ($urandom_range(0, 3) != 0);
            fl   = ($urandom_range(0, 49) == 0);
            cycle(v, ctl, a, b, 5'($urandom), ordy, fl, "rand");
            if (i == 700) do_reset("rand_rst");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
